// File: rtl/soc_network_adapter_switch.sv
// rtl/soc_network_adapter_switch.sv - NoC adapter: round-robin TX packet arbiter with FIFO, class-routed RX demux with drop counting
module soc_network_adapter_switch #(
  parameter int FLIT_WIDTH  = 32,
  parameter int PORTS       = 2,
  parameter int DEPTH       = 4,
  parameter int CLASS_LSB   = 24,
  parameter int CLASS_WIDTH = 3,
  parameter logic [PORTS*CLASS_WIDTH-1:0] MAPPING = {3'd2, 3'd1},
  parameter int CNT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*FLIT_WIDTH-1:0] tx_in_flit,
  input  logic [PORTS-1:0]            tx_in_last,
  input  logic [PORTS-1:0]            tx_in_valid,
  output logic [PORTS-1:0]            tx_in_ready,
  output logic [FLIT_WIDTH-1:0]       noc_out_flit,
  output logic                        noc_out_last,
  output logic                        noc_out_valid,
  input  logic                        noc_out_ready,
  input  logic [FLIT_WIDTH-1:0]       noc_in_flit,
  input  logic                        noc_in_last,
  input  logic                        noc_in_valid,
  output logic                        noc_in_ready,
  output logic [PORTS*FLIT_WIDTH-1:0] rx_out_flit,
  output logic [PORTS-1:0]            rx_out_last,
  output logic [PORTS-1:0]            rx_out_valid,
  input  logic [PORTS-1:0]            rx_out_ready,
  output logic [CNT_WIDTH-1:0]        drop_count,
  output logic                        drop_pulse
);
  localparam int PW = $clog2(PORTS);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, LOCK} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_DROP} rx_state_t;

  tx_state_t             r_tx_state, w_tx_state_nxt;
  logic [PW-1:0]         r_rr, w_rr_nxt, r_tx_lock, w_tx_lock_nxt;
  logic [PW-1:0]         w_winner, w_idx, w_tx_sel;
  logic                  w_found, w_wr, w_rd, w_full, w_empty, w_wr_last;
  logic [FLIT_WIDTH-1:0] w_wr_flit;
  logic [AW:0]           r_wptr, r_rptr;
  logic [FLIT_WIDTH:0]   r_mem [DEPTH];

  rx_state_t             r_rx_state, w_rx_state_nxt;
  logic [PW-1:0]         r_rx_port, w_rx_port_nxt, w_match_port, w_fwd_port;
  logic                  w_match, w_fwd, w_drop;
  logic [CLASS_WIDTH-1:0] w_class;
  logic [CNT_WIDTH-1:0]  r_drop_count;
  logic                  r_drop_pulse;

  // Round-robin search: first valid port starting at rr, wrapping modulo PORTS
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_rr) + k) % PORTS);
      for (int p = 0; p < PORTS; p++) begin
        if (w_idx == PW'(p) && tx_in_valid[p]) begin
          w_found  = 1'b1;
          w_winner = w_idx;
        end
      end
    end
  end

  // TX arbiter next state, per-port ready and FIFO write data
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_rr_nxt       = r_rr;
    w_tx_lock_nxt  = r_tx_lock;
    w_tx_sel       = (r_tx_state == LOCK) ? r_tx_lock : w_winner;
    tx_in_ready    = '0;
    w_wr_flit      = '0;
    w_wr_last      = 1'b0;
    if (rst && !w_full) begin
      if (r_tx_state == LOCK) tx_in_ready[r_tx_lock] = 1'b1;
      else if (w_found)       tx_in_ready[w_winner]  = 1'b1;
    end
    for (int p = 0; p < PORTS; p++) begin
      if (w_tx_sel == PW'(p)) begin
        w_wr_flit = tx_in_flit[p*FLIT_WIDTH +: FLIT_WIDTH];
        w_wr_last = tx_in_last[p];
      end
    end
    w_wr = |(tx_in_valid & tx_in_ready);
    if (w_wr) begin
      if (r_tx_state == IDLE) begin
        w_rr_nxt = PW'((int'(w_winner) + 1) % PORTS);
        if (!w_wr_last) begin
          w_tx_state_nxt = LOCK;
          w_tx_lock_nxt  = w_winner;
        end
      end else if (w_wr_last) begin
        w_tx_state_nxt = IDLE;
      end
    end
  end

  assign w_full        = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty       = (r_wptr == r_rptr);
  assign w_rd          = !w_empty && noc_out_ready;
  assign noc_out_valid = !w_empty;
  assign {noc_out_last, noc_out_flit} = r_mem[r_rptr[AW-1:0]];

  // TX arbiter state and FIFO pointers; reset drops locks and queued flits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= IDLE;
      r_rr       <= '0;
      r_tx_lock  <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_rr       <= w_rr_nxt;
      r_tx_lock  <= w_tx_lock_nxt;
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // FIFO storage of {last, flit}; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= {w_wr_last, w_wr_flit};
  end

  assign w_class = noc_in_flit[CLASS_LSB +: CLASS_WIDTH];

  // Lowest port whose mapped class equals the header class
  always_comb begin
    w_match      = 1'b0;
    w_match_port = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (MAPPING[i*CLASS_WIDTH +: CLASS_WIDTH] == w_class) begin
        w_match      = 1'b1;
        w_match_port = PW'(i);
      end
    end
  end

  // RX next state and combinational pass-through to the selected port
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_port_nxt  = r_rx_port;
    w_fwd          = 1'b0;
    w_fwd_port     = r_rx_port;
    w_drop         = 1'b0;
    noc_in_ready   = 1'b0;
    rx_out_valid   = '0;
    if (rst) begin
      case (r_rx_state)
        R_IDLE: begin
          if (w_match) begin
            w_fwd      = 1'b1;
            w_fwd_port = w_match_port;
            if (noc_in_valid && rx_out_ready[w_match_port] && !noc_in_last) begin
              w_rx_state_nxt = R_FWD;
              w_rx_port_nxt  = w_match_port;
            end
          end else begin
            noc_in_ready = 1'b1;
            if (noc_in_valid) begin
              w_drop = 1'b1;
              if (!noc_in_last) w_rx_state_nxt = R_DROP;
            end
          end
        end
        R_FWD: begin
          w_fwd = 1'b1;
          if (noc_in_valid && rx_out_ready[r_rx_port] && noc_in_last) w_rx_state_nxt = R_IDLE;
        end
        R_DROP: begin
          noc_in_ready = 1'b1;
          if (noc_in_valid && noc_in_last) w_rx_state_nxt = R_IDLE;
        end
        default: w_rx_state_nxt = R_IDLE;
      endcase
      if (w_fwd) begin
        rx_out_valid[w_fwd_port] = noc_in_valid;
        noc_in_ready             = rx_out_ready[w_fwd_port];
      end
    end
  end

  assign rx_out_flit = {PORTS{noc_in_flit}};
  assign rx_out_last = {PORTS{noc_in_last}};
  assign drop_count  = r_drop_count;
  assign drop_pulse  = r_drop_pulse;

  // RX state, locked port and saturating drop counter with one-cycle strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state   <= R_IDLE;
      r_rx_port    <= '0;
      r_drop_count <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_state_nxt;
      r_rx_port    <= w_rx_port_nxt;
      r_drop_pulse <= w_drop;
      if (w_drop && !(&r_drop_count)) r_drop_count <= r_drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_soc_network_adapter_switch.sv
// tb/tb_soc_network_adapter_switch.sv - directed self-checking bench for soc_network_adapter_switch
module tb_soc_network_adapter_switch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] tx_in_flit;
  logic [1:0]  tx_in_last, tx_in_valid, tx_in_ready;
  logic [31:0] noc_out_flit;
  logic        noc_out_last, noc_out_valid, noc_out_ready;
  logic [31:0] noc_in_flit;
  logic        noc_in_last, noc_in_valid, noc_in_ready;
  logic [63:0] rx_out_flit;
  logic [1:0]  rx_out_last, rx_out_valid, rx_out_ready;
  logic [1:0]  drop_count;
  logic        drop_pulse;

  logic [31:0] tf [2];
  logic        tv [2];
  logic        tl [2];
  assign tx_in_flit  = {tf[1], tf[0]};
  assign tx_in_valid = {tv[1], tv[0]};
  assign tx_in_last  = {tl[1], tl[0]};

  always #5 clk = ~clk;

  soc_network_adapter_switch #(.CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .tx_in_flit(tx_in_flit), .tx_in_last(tx_in_last), .tx_in_valid(tx_in_valid), .tx_in_ready(tx_in_ready),
    .noc_out_flit(noc_out_flit), .noc_out_last(noc_out_last), .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready),
    .noc_in_flit(noc_in_flit), .noc_in_last(noc_in_last), .noc_in_valid(noc_in_valid), .noc_in_ready(noc_in_ready),
    .rx_out_flit(rx_out_flit), .rx_out_last(rx_out_last), .rx_out_valid(rx_out_valid), .rx_out_ready(rx_out_ready),
    .drop_count(drop_count), .drop_pulse(drop_pulse)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [32:0] q_out [$];
  int          n_pulse = 0;
  logic [1:0]  first_ready;

  always @(negedge clk) begin
    if (noc_out_valid && noc_out_ready) q_out.push_back({noc_out_last, noc_out_flit});
    if (drop_pulse) n_pulse++;
  end

  function automatic logic [31:0] mkf(input int p, input int k, input int b);
    return 32'hA000_0000 | 32'(p << 16) | 32'(k << 8) | 32'(b);
  endfunction

  function automatic logic [31:0] hdr(input int cls, input int tag);
    return 32'(cls << 24) | 32'(tag);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic run_tx(input int n0, input int n1, input int len, input int ncyc, output int acc);
    int np [2];
    int pk [2];
    int bt [2];
    np[0] = n0; np[1] = n1;
    pk = '{0, 0};
    bt = '{0, 0};
    acc = 0;
    for (int c = 0; c < ncyc; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (pk[p] < np[p]) begin
          tv[p] = 1'b1;
          tf[p] = mkf(p, pk[p], bt[p]);
          tl[p] = (bt[p] == len - 1);
        end else begin
          tv[p] = 1'b0;
        end
      end
      @(negedge clk);
      if (c == 0) first_ready = tx_in_ready;
      for (int p = 0; p < 2; p++) begin
        if (tv[p] && tx_in_ready[p]) begin
          acc++;
          bt[p]++;
          if (bt[p] == len) begin
            bt[p] = 0;
            pk[p]++;
          end
        end
      end
      tick();
    end
    tv[0] = 1'b0;
    tv[1] = 1'b0;
  endtask

  initial begin
    int acc;
    int base;
    int p0;
    int n;

    tv[0] = 1'b1; tv[1] = 1'b1;
    tf[0] = mkf(0, 0, 0); tf[1] = mkf(1, 0, 0);
    tl[0] = 1'b0; tl[1] = 1'b0;
    noc_out_ready = 1'b1;
    noc_in_valid  = 1'b1;
    noc_in_flit   = hdr(1, 0);
    noc_in_last   = 1'b0;
    rx_out_ready  = 2'b11;

    #2;
    check("rst_tx_ready", tx_in_ready, 2'b00);
    check("rst_noc_out_valid", noc_out_valid, 1'b0);
    check("rst_noc_in_ready", noc_in_ready, 1'b0);
    check("rst_rx_out_valid", rx_out_valid, 2'b00);
    check("rst_drop_pulse", drop_pulse, 1'b0);
    check("rst_drop_count", drop_count, 2'd0);
    tick();
    check("rst_tx_ready_edge", tx_in_ready, 2'b00);
    check("rst_noc_out_valid_edge", noc_out_valid, 1'b0);
    tv[0] = 1'b0; tv[1] = 1'b0;
    noc_in_valid = 1'b0;
    rst = 1'b1;

    // first-flit latency out of an empty FIFO
    noc_out_ready = 1'b0;
    tv[0] = 1'b1; tf[0] = mkf(0, 9, 0); tl[0] = 1'b1;
    @(negedge clk);
    check("lat_valid_c0", noc_out_valid, 1'b0);
    check("release_ready", tx_in_ready, 2'b01);
    tick();
    tv[0] = 1'b0;
    @(negedge clk);
    check("lat_valid_c1", noc_out_valid, 1'b1);
    check("lat_flit", {noc_out_last, noc_out_flit}, {1'b1, mkf(0, 9, 0)});
    tick();
    noc_out_ready = 1'b1;
    tick();
    tick();

    // two ports streaming 3-flit packets: whole packets alternate P0,P1
    do_reset();
    base = q_out.size();
    run_tx(3, 3, 3, 30, acc);
    repeat (3) tick();
    check("rr_first_ready", first_ready, 2'b01);
    check("rr_accepted", acc, 18);
    check("rr_out_count", q_out.size() - base, 18);
    n = 0;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 3; b++) begin
          if (base + n < q_out.size())
            check("rr_flit", q_out[base + n], {(b == 2), mkf(p, k, b)});
          n++;
        end

    // FIFO fill with output stalled, full blocks even when a read happens
    noc_out_ready = 1'b0;
    base = q_out.size();
    run_tx(6, 0, 1, 10, acc);
    check("full_accepted", acc, 4);
    tv[0] = 1'b1; tf[0] = mkf(0, 4, 0); tl[0] = 1'b1;
    noc_out_ready = 1'b1;
    @(negedge clk);
    check("full_rd_ready", tx_in_ready, 2'b00);
    tick();
    tv[0] = 1'b0;
    repeat (5) tick();
    check("full_out_count", q_out.size() - base, 4);
    for (int k = 0; k < 4; k++)
      if (base + k < q_out.size())
        check("full_flit", q_out[base + k], {1'b1, mkf(0, k, 0)});

    // reset in the middle of a 4-flit packet from port 1
    do_reset();
    noc_out_ready = 1'b0;
    tv[1] = 1'b1; tf[1] = mkf(1, 0, 0); tl[1] = 1'b0;
    @(negedge clk);
    check("mid_ready", tx_in_ready, 2'b10);
    tick();
    tf[1] = mkf(1, 0, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", noc_out_valid, 1'b0);
    check("mid_rst_ready", tx_in_ready, 2'b00);
    tick();
    tv[1] = 1'b0;
    tick();
    rst = 1'b1;
    noc_out_ready = 1'b1;
    base = q_out.size();
    run_tx(1, 1, 2, 10, acc);
    repeat (3) tick();
    check("mid_first_ready", first_ready, 2'b01);
    check("mid_out_count", q_out.size() - base, 4);
    n = 0;
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 2; b++) begin
        if (base + n < q_out.size())
          check("mid_flit", q_out[base + n], {(b == 1), mkf(p, 0, b)});
        n++;
      end

    // RX routing: class 2 -> port 1, class 1 -> port 0, locked body flits
    do_reset();
    rx_out_ready = 2'b11;
    noc_in_valid = 1'b1; noc_in_flit = hdr(2, 1); noc_in_last = 1'b0;
    @(negedge clk);
    check("rx_c2_valid", rx_out_valid, 2'b10);
    check("rx_c2_ready", noc_in_ready, 1'b1);
    check("rx_c2_flit", rx_out_flit[63:32], hdr(2, 1));
    tick();
    noc_in_flit = hdr(1, 2); noc_in_last = 1'b1;
    rx_out_ready = 2'b01;
    @(negedge clk);
    check("rx_stall_ready", noc_in_ready, 1'b0);
    check("rx_lock_valid", rx_out_valid, 2'b10);
    tick();
    rx_out_ready = 2'b11;
    @(negedge clk);
    check("rx_unstall_ready", noc_in_ready, 1'b1);
    tick();
    noc_in_flit = hdr(1, 3); noc_in_last = 1'b0;
    @(negedge clk);
    check("rx_c1_valid", rx_out_valid, 2'b01);
    check("rx_c1_flit", rx_out_flit[31:0], hdr(1, 3));
    tick();
    noc_in_flit = hdr(5, 4); noc_in_last = 1'b1;
    @(negedge clk);
    check("rx_c1_body_valid", rx_out_valid, 2'b01);
    tick();
    noc_in_valid = 1'b0;
    tick();
    check("rx_no_drop", drop_count, 2'd0);

    // unmatched 3-flit packet is swallowed whole
    p0 = n_pulse;
    for (int b = 0; b < 3; b++) begin
      noc_in_valid = 1'b1;
      noc_in_flit  = (b == 0) ? hdr(5, b) : hdr(1, b);
      noc_in_last  = (b == 2);
      @(negedge clk);
      check("drop_ready", noc_in_ready, 1'b1);
      check("drop_no_valid", rx_out_valid, 2'b00);
      tick();
    end
    noc_in_valid = 1'b0;
    tick();
    tick();
    check("drop_count_1", drop_count, 2'd1);
    check("drop_pulses_1", n_pulse - p0, 1);

    // saturation of a 2-bit drop counter
    do_reset();
    check("sat_rst_count", drop_count, 2'd0);
    p0 = n_pulse;
    noc_in_valid = 1'b1; noc_in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      noc_in_flit = hdr(5, i);
      @(negedge clk);
      check("sat_ready", noc_in_ready, 1'b1);
      tick();
    end
    noc_in_valid = 1'b0;
    tick();
    tick();
    check("sat_count", drop_count, 2'd3);
    check("sat_pulses", n_pulse - p0, 5);
    noc_in_valid = 1'b1; noc_in_flit = hdr(1, 9); noc_in_last = 1'b1;
    @(negedge clk);
    check("sat_then_route", rx_out_valid, 2'b01);
    tick();
    noc_in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
